// File: rtl/ma_pkg.sv
// Shared definitions for the memory-access stage: opcode classes,
// FSM state encoding and default widths.
package ma_pkg;

    localparam int MA_DATA_W    = 16;
    localparam int MA_ADDR_W    = 16;
    localparam int MA_REG_IDX_W = 5;
    localparam int MA_CTRL_W    = 4;

    localparam logic [3:0] LOAD  = 4'b1100;
    localparam logic [3:0] STORE = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        STORE_WAIT
    } ma_state_e;

endpackage

// File: rtl/ma_if.sv
// Data-memory request bus: req/we/address/wdata out, ack/rdata back.
// master = MA stage, slave = memory.
interface ma_if
    import ma_pkg::*;
#(
    parameter int DATA_W = MA_DATA_W,
    parameter int ADDR_W = MA_ADDR_W
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] address_to_memory;
    logic [DATA_W-1:0] data_to_memory;
    logic              mem_ack;
    logic [DATA_W-1:0] data_from_memory;

    modport master (
        output mem_req,
        output mem_we,
        output address_to_memory,
        output data_to_memory,
        input  mem_ack,
        input  data_from_memory
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  address_to_memory,
        input  data_to_memory,
        output mem_ack,
        output data_from_memory
    );

endinterface

// File: rtl/ma_store_buffer.sv
// One-entry posted store buffer: push latches addr/data and sets busy,
// ack while busy clears it. Ports: clk, rst_n, push_*, ack_i, busy/addr/data.
module ma_store_buffer
    import ma_pkg::*;
#(
    parameter int ADDR_W = MA_ADDR_W,
    parameter int DATA_W = MA_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              ack_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        busy_d = busy_q;
        addr_d = addr_q;
        data_d = data_q;
        if (busy_q && ack_i) begin
            busy_d = 1'b0;
        end
        if (push_i) begin
            busy_d = 1'b1;
            addr_d = push_addr_i;
            data_d = push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign busy_o = busy_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/memory_access_stage.sv
// MA pipeline stage: forwards ALU results, runs loads/stores over ma_if
// with a req/ack handshake and stalls EX while an access is outstanding.
// Ports: clk, rst_n, EX-side *_ex inputs, stall_ma, mem (ma_if.master),
// MA-side *_ma outputs. Optional MA_STORE_BUFFER_EN adds a posted store.
module memory_access_stage
    import ma_pkg::*;
#(
    parameter int DATA_W    = MA_DATA_W,
    parameter int ADDR_W    = MA_ADDR_W,
    parameter int REG_IDX_W = MA_REG_IDX_W,
    parameter int CTRL_W    = MA_CTRL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_ex,
    input  logic [CTRL_W-1:0]    control_ex,
    input  logic [DATA_W-1:0]    result_ex,
    input  logic [DATA_W-1:0]    reg_data_ex,
    input  logic [REG_IDX_W-1:0] dest_reg_index_ex,
    input  logic                 dest_reg_write_en_ex,
    output logic                 stall_ma,
    ma_if.master                 mem,
    output logic                 valid_ma,
    output logic [CTRL_W-1:0]    control_ma,
    output logic [DATA_W-1:0]    result_ma,
    output logic [DATA_W-1:0]    data_ma,
    output logic [REG_IDX_W-1:0] dest_reg_index_ma,
    output logic                 dest_reg_write_en_ma
);

    ma_state_e             state_q, state_d;
    logic                  valid_q, valid_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [DATA_W-1:0]     res_q, res_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [REG_IDX_W-1:0]  idx_q, idx_d;
    logic                  wen_q, wen_d;
    // Fields of the in-flight access, kept apart so MA outputs hold.
    logic [CTRL_W-1:0]     p_ctrl_q, p_ctrl_d;
    logic [DATA_W-1:0]     p_res_q, p_res_d;
    logic [REG_IDX_W-1:0]  p_idx_q, p_idx_d;
    logic                  p_wen_q, p_wen_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  is_load, is_store, take_ex;
    logic [ADDR_W-1:0]     ex_addr;

    assign is_load  = (control_ex == CTRL_W'(LOAD));
    assign is_store = (control_ex == CTRL_W'(STORE));
    assign ex_addr  = result_ex[ADDR_W-1:0];

`ifdef MA_STORE_BUFFER_EN
    logic              sb_push, sb_busy;
    logic [ADDR_W-1:0] sb_addr;
    logic [DATA_W-1:0] sb_data;

    ma_store_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (sb_push),
        .push_addr_i (ex_addr),
        .push_data_i (reg_data_ex),
        .ack_i       (mem.mem_ack),
        .busy_o      (sb_busy),
        .addr_o      (sb_addr),
        .data_o      (sb_data)
    );
`else
    logic [DATA_W-1:0] wdata_q, wdata_d;
`endif

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        ctrl_d   = ctrl_q;
        res_d    = res_q;
        data_d   = data_q;
        idx_d    = idx_q;
        wen_d    = wen_q;
        p_ctrl_d = p_ctrl_q;
        p_res_d  = p_res_q;
        p_idx_d  = p_idx_q;
        p_wen_d  = p_wen_q;
        addr_d   = addr_q;
        take_ex  = 1'b0;
`ifdef MA_STORE_BUFFER_EN
        sb_push  = 1'b0;
`else
        wdata_d  = wdata_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_ex) begin
                    unique case (1'b1)
                        is_load: begin
                            state_d  = LOAD_WAIT;
                            addr_d   = ex_addr;
                            p_ctrl_d = control_ex;
                            p_res_d  = result_ex;
                            p_idx_d  = dest_reg_index_ex;
                            p_wen_d  = dest_reg_write_en_ex;
                        end
                        is_store: begin
                            state_d  = STORE_WAIT;
`ifdef MA_STORE_BUFFER_EN
                            sb_push  = 1'b1;
                            take_ex  = 1'b1;
`else
                            addr_d   = ex_addr;
                            wdata_d  = reg_data_ex;
                            p_ctrl_d = control_ex;
                            p_res_d  = result_ex;
                            p_idx_d  = dest_reg_index_ex;
`endif
                        end
                        default: take_ex = 1'b1;
                    endcase
                end
            end
            LOAD_WAIT: begin
                if (mem.mem_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    ctrl_d  = p_ctrl_q;
                    res_d   = p_res_q;
                    data_d  = mem.data_from_memory;
                    idx_d   = p_idx_q;
                    wen_d   = p_wen_q;
                end
            end
            STORE_WAIT: begin
`ifdef MA_STORE_BUFFER_EN
                // Draining: ALU ops flow past, memory ops wait.
                if (mem.mem_ack) begin
                    state_d = IDLE;
                end
                if (valid_ex && !(is_load || is_store)) begin
                    take_ex = 1'b1;
                end
`else
                if (mem.mem_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    ctrl_d  = p_ctrl_q;
                    res_d   = p_res_q;
                    idx_d   = p_idx_q;
                    wen_d   = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (take_ex) begin
            valid_d = 1'b1;
            ctrl_d  = control_ex;
            res_d   = result_ex;
            idx_d   = dest_reg_index_ex;
            wen_d   = dest_reg_write_en_ex & ~is_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            res_q    <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            wen_q    <= 1'b0;
            p_ctrl_q <= '0;
            p_res_q  <= '0;
            p_idx_q  <= '0;
            p_wen_q  <= 1'b0;
            addr_q   <= '0;
`ifndef MA_STORE_BUFFER_EN
            wdata_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            res_q    <= res_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            wen_q    <= wen_d;
            p_ctrl_q <= p_ctrl_d;
            p_res_q  <= p_res_d;
            p_idx_q  <= p_idx_d;
            p_wen_q  <= p_wen_d;
            addr_q   <= addr_d;
`ifndef MA_STORE_BUFFER_EN
            wdata_q  <= wdata_d;
`endif
        end
    end

    assign mem.mem_req = (state_q != IDLE);
    assign mem.mem_we  = (state_q == STORE_WAIT);

`ifdef MA_STORE_BUFFER_EN
    // A memory op behind a draining store is held off until the drain acks.
    assign stall_ma = (state_q == LOAD_WAIT) ||
                      ((state_q == STORE_WAIT) && valid_ex &&
                       (is_load || is_store));
    assign mem.address_to_memory = sb_busy ? sb_addr : addr_q;
    assign mem.data_to_memory    = sb_data;
`else
    assign stall_ma = (state_q != IDLE);
    assign mem.address_to_memory = addr_q;
    assign mem.data_to_memory    = wdata_q;
`endif

    assign valid_ma             = valid_q;
    assign control_ma           = ctrl_q;
    assign result_ma            = res_q;
    assign data_ma              = data_q;
    assign dest_reg_index_ma    = idx_q;
    assign dest_reg_write_en_ma = wen_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed vector table,
// reset-abandon sequence, and a randomized cycle schedule built from timing rules.
`timescale 1ns/1ps
module tb_memory_access_stage;
    import ma_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int NC = 3000;
`ifdef MA_STORE_BUFFER_EN
    localparam int ST_LAT = 1;
`else
    localparam int ST_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          valid_ex, dest_reg_write_en_ex;
    logic [CW-1:0] control_ex;
    logic [DW-1:0] result_ex, reg_data_ex;
    logic [RW-1:0] dest_reg_index_ex;
    logic          stall_ma, valid_ma, dest_reg_write_en_ma;
    logic [CW-1:0] control_ma;
    logic [DW-1:0] result_ma, data_ma;
    logic [RW-1:0] dest_reg_index_ma;

    ma_if #(.DATA_W(DW), .ADDR_W(AW)) mem ();

    memory_access_stage #(
        .DATA_W(DW), .ADDR_W(AW), .REG_IDX_W(RW), .CTRL_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_ex(valid_ex), .control_ex(control_ex),
        .result_ex(result_ex), .reg_data_ex(reg_data_ex),
        .dest_reg_index_ex(dest_reg_index_ex),
        .dest_reg_write_en_ex(dest_reg_write_en_ex),
        .stall_ma(stall_ma), .mem(mem),
        .valid_ma(valid_ma), .control_ma(control_ma),
        .result_ma(result_ma), .data_ma(data_ma),
        .dest_reg_index_ma(dest_reg_index_ma),
        .dest_reg_write_en_ma(dest_reg_write_en_ma)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t",
                      name, act, exp, $time);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {59'd0, stall_ma, mem.mem_req, mem.mem_we,
                              valid_ma, dest_reg_write_en_ma}, 64'd0);
        chk({tag, "_ma"}, {23'd0, control_ma, result_ma, data_ma,
                           dest_reg_index_ma}, 64'd0);
        chk({tag, "_bus"}, {32'd0, mem.address_to_memory,
                            mem.data_to_memory}, 64'd0);
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] r, input logic [DW-1:0] d,
                         input logic [RW-1:0] i, input logic w);
        valid_ex = v; control_ex = c; result_ex = r;
        reg_data_ex = d; dest_reg_index_ex = i; dest_reg_write_en_ex = w;
    endtask

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] res;
        logic [DW-1:0] regd;
        logic [RW-1:0] idx;
        logic          wen;
        int            waits;
        logic [DW-1:0] rdata;
        int            lat;
        int            reqs;
        logic          wen_ma;
        logic          chk_data;
    } vec_t;
    vec_t vt[4];

    task automatic run_vec(input vec_t v, input int id);
        int   lat = 0, reqs = 0, wcnt = 0;
        bit   seen = 0, stall_ok = 1, bus_ok = 1;
        logic exp_stall;
        logic [63:0] got_ma = '0;
        logic [DW-1:0] got_data = '0;
        drive(1'b1, v.ctrl, v.res, v.regd, v.idx, v.wen);
        @(posedge clk); #1;
        drive(1'b0, CW'(0), '0, '0, '0, 1'b0);
        for (int k = 1; k <= 20 && !seen; k++) begin
            mem.mem_ack = 1'b0;
            exp_stall = mem.mem_req;
`ifdef MA_STORE_BUFFER_EN
            if (v.ctrl == STORE) exp_stall = 1'b0;
`endif
            if (mem.mem_req) begin
                reqs++;
                if (mem.mem_we !== (v.ctrl == STORE)) bus_ok = 0;
                if (mem.address_to_memory !== v.res[AW-1:0]) bus_ok = 0;
                if (v.ctrl == STORE && mem.data_to_memory !== v.regd)
                    bus_ok = 0;
                if (wcnt == v.waits) begin
                    mem.mem_ack = 1'b1;
                    mem.data_from_memory = v.rdata;
                end
                wcnt++;
            end
            if (stall_ma !== exp_stall) stall_ok = 0;
            #2;
            if (valid_ma === 1'b1) begin
                seen = 1; lat = k; got_data = data_ma;
                got_ma = {39'd0, control_ma, result_ma, dest_reg_index_ma,
                          dest_reg_write_en_ma};
            end
            @(posedge clk); #1;
        end
        mem.mem_ack = 1'b0;
        chk($sformatf("v%0d_latency", id), lat, v.lat);
        chk($sformatf("v%0d_req_cycles", id), reqs, v.reqs);
        chk($sformatf("v%0d_stall", id), stall_ok, 1);
        chk($sformatf("v%0d_bus", id), bus_ok, 1);
        chk($sformatf("v%0d_fields", id), got_ma,
            {39'd0, v.ctrl, v.res, v.idx, v.wen_ma});
        if (v.chk_data) chk($sformatf("v%0d_data", id), got_data, v.rdata);
        #2;
        chk($sformatf("v%0d_pulse", id), {valid_ma, stall_ma}, 2'b00);
        @(posedge clk); #1;
    endtask

    // Cycle schedule: s_* = stimulus, e_* = expected, indexed by cycle.
    logic          s_valid[NC], s_wen[NC], s_ack[NC];
    logic [CW-1:0] s_ctrl[NC];
    logic [DW-1:0] s_res[NC], s_regd[NC], s_rdata[NC];
    logic [RW-1:0] s_idx[NC];
    logic          e_stall[NC], e_req[NC], e_we[NC], e_valid[NC];
    logic          e_load[NC], e_wen[NC];
    logic [AW-1:0] e_addr[NC];
    logic [DW-1:0] e_wd[NC], e_res[NC], e_data[NC];
    logic [CW-1:0] e_ctrl[NC];
    logic [RW-1:0] e_idx[NC];

    task automatic retire(input int t, input logic [CW-1:0] c,
                          input logic [DW-1:0] r, input logic [RW-1:0] i,
                          input logic w, input logic ld,
                          input logic [DW-1:0] d);
        e_valid[t] = 1; e_ctrl[t] = c; e_res[t] = r; e_idx[t] = i;
        e_wen[t] = w; e_load[t] = ld; e_data[t] = d;
    endtask

    task automatic build();
        int c = 1, n = 0, drain_end = -1;
        for (int i = 0; i < NC; i++) begin
            s_valid[i] = 0; s_ctrl[i] = CW'($urandom);
            s_res[i] = DW'($urandom); s_regd[i] = DW'($urandom);
            s_idx[i] = RW'($urandom); s_wen[i] = 1'($urandom);
            s_ack[i] = 0; s_rdata[i] = DW'($urandom);
            e_stall[i] = 0; e_req[i] = 0; e_we[i] = 0; e_valid[i] = 0;
            e_addr[i] = '0; e_wd[i] = '0;
        end
        while (c < NC - 40) begin
            int kind, w, s, r;
            logic [CW-1:0] ctl;
            logic [DW-1:0] res, rd, regd;
            logic [RW-1:0] idx;
            logic wen;
            if (n < 8) begin kind = (n % 2 == 0) ? 1 : 2; w = 0; end
            else if (n == 8) begin kind = 2; w = 4; end
            else if (n == 9) begin kind = 0; w = 0; end
            else if (n == 10) begin kind = 1; w = 1; end
            else begin
                r = $urandom_range(0, 9);
                kind = (r < 4) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : 3;
                w = $urandom_range(0, 3);
            end
            n++;
            if (kind == 3) begin
                s_valid[c] = 0; c++;
                continue;
            end
            ctl = (kind == 1) ? LOAD : (kind == 2) ? STORE
                : CW'($urandom_range(0, 11));
            res = DW'($urandom); regd = DW'($urandom);
            idx = RW'($urandom); wen = 1'($urandom); rd = DW'($urandom);
            s = c;
`ifdef MA_STORE_BUFFER_EN
            if (kind != 0 && c <= drain_end) s = drain_end + 1;
`endif
            for (int k = c; k <= s; k++) begin
                s_valid[k] = 1; s_ctrl[k] = ctl; s_res[k] = res;
                s_regd[k] = regd; s_idx[k] = idx; s_wen[k] = wen;
                if (k < s) e_stall[k] = 1;
            end
            if (kind == 0) begin
                retire(s + 1, ctl, res, idx, wen, 0, '0);
                c = s + 1;
                continue;
            end
            for (int k = s + 1; k <= s + 1 + w; k++) begin
                e_req[k] = 1; e_we[k] = (kind == 2);
                e_addr[k] = res[AW-1:0]; e_wd[k] = regd;
            end
            s_ack[s + 1 + w] = 1; s_rdata[s + 1 + w] = rd;
`ifdef MA_STORE_BUFFER_EN
            if (kind == 2) begin
                retire(s + 1, ctl, res, idx, 0, 0, '0);
                drain_end = s + 1 + w;
                c = s + 1;
                continue;
            end
`endif
            for (int k = s + 1; k <= s + 1 + w; k++) begin
                e_stall[k] = 1; s_valid[k] = 1'($urandom);
            end
            retire(s + 2 + w, ctl, res, idx, (kind == 1) ? wen : 1'b0,
                   kind == 1, rd);
            c = s + 2 + w;
        end
        for (int i = 0; i < NC; i++)
            if (!e_req[i] && $urandom_range(0, 3) == 0) s_ack[i] = 1;
    endtask

    task automatic run_sched();
        logic [63:0] hold = '0;
        @(posedge clk); #1;
        for (int c = 0; c < NC; c++) begin
            drive(s_valid[c], s_ctrl[c], s_res[c], s_regd[c], s_idx[c],
                  s_wen[c]);
            mem.mem_ack = s_ack[c];
            mem.data_from_memory = s_rdata[c];
            #2;
            if (e_valid[c])
                hold = {39'd0, e_ctrl[c], e_res[c], e_idx[c], e_wen[c]};
            chk($sformatf("c%0d_stall", c), stall_ma, e_stall[c]);
            chk($sformatf("c%0d_req", c), mem.mem_req, e_req[c]);
            chk($sformatf("c%0d_valid", c), valid_ma, e_valid[c]);
            chk($sformatf("c%0d_ma", c), {39'd0, control_ma, result_ma,
                dest_reg_index_ma, dest_reg_write_en_ma}, hold);
            if (e_req[c]) begin
                chk($sformatf("c%0d_we", c), mem.mem_we, e_we[c]);
                chk($sformatf("c%0d_addr", c), mem.address_to_memory,
                    e_addr[c]);
                if (e_we[c])
                    chk($sformatf("c%0d_wdata", c), mem.data_to_memory,
                        e_wd[c]);
            end
            if (e_valid[c] && e_load[c])
                chk($sformatf("c%0d_data", c), data_ma, e_data[c]);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        drive(1'b0, CW'(0), '0, '0, '0, 1'b0);
        mem.mem_ack = 1'b0;
        mem.data_from_memory = '0;
        vt[0] = '{CW'(0), 16'h0042, 16'h0, 5'd3, 1'b1, 0, 16'h0,
                  1, 0, 1'b1, 1'b0};
        vt[1] = '{LOAD, 16'h000A, 16'h0, 5'd7, 1'b1, 3, 16'hBEEF,
                  5, 4, 1'b1, 1'b1};
        vt[2] = '{STORE, 16'h0010, 16'h1234, 5'd2, 1'b1, 0, 16'h0,
                  ST_LAT, 1, 1'b0, 1'b0};
        vt[3] = '{CW'(5), 16'hFFFF, 16'h0, 5'd31, 1'b0, 0, 16'h0,
                  1, 0, 1'b0, 1'b0};
        #12;
        chk_zero("reset");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) run_vec(vt[i], i);

        drive(1'b1, LOAD, 16'h0033, '0, 5'd9, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, CW'(0), '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        chk("rst_pre_req", mem.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_async");
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            mem.mem_ack = 1'b1;
            mem.data_from_memory = 16'hDEAD;
            #2;
            chk($sformatf("late_ack%0d", k),
                {valid_ma, stall_ma, mem.mem_req}, 3'b000);
        end
        mem.mem_ack = 1'b0;
        chk("late_ack_data", data_ma, 16'h0000);

        build();
        run_sched();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
